// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN0 = 3'd0,
    ST_LEN1 = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  localparam logic [31:0] BREAK_INSTR = 32'h0000000D;
  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_LOAD);
  endfunction

endpackage

// File: rtl/imem_loader_ram.sv
// rtl/imem_loader_ram.sv - instruction RAM, one synchronous write port, one asynchronous read port
module imem_ram #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 32
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  // Contents are deliberately not reset so a program survives a reset pulse.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader, instruction fetch port and run supervisor
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic [31:0] raddr,
  output logic [31:0] instr,
  output logic        core_reset,
  input  logic        core_halted,
  output logic        done,
  output logic        error,
  output logic [31:0] cycles,
  output logic [2:0]  state
);

  localparam int DEPTH  = 1 << ADDR_SIZE;
  localparam int LEN_W  = 8 * LEN_BYTES;
  localparam int WORD_W = 8 * WORD_BYTES;

  state_t cur, nxt;

  logic [7:0]          len_lo;
  logic [LEN_W-1:0]    n_len;
  logic [ADDR_SIZE:0]  n_words;
  logic [ADDR_SIZE-1:0] word_idx;
  logic [1:0]          byte_idx;
  logic [WORD_W-9:0]   asm_q;
  logic                accept;
  logic                len_bad;
  logic                word_done;
  logic                last_word;
  logic                at_timeout;
  logic [WORD_W-1:0]   ram_wdata;
  logic [WORD_W-1:0]   ram_rdata;

  assign in_ready   = takes_bytes(cur);
  assign accept     = in_valid && in_ready;
  assign n_len      = {in_byte, len_lo};
  assign len_bad    = (n_len == '0) || (32'(n_len) > 32'(DEPTH));
  assign word_done  = (cur == ST_LOAD) && accept && (byte_idx == 2'(WORD_BYTES - 1));
  assign last_word  = ({1'b0, word_idx} == (n_words - 1'b1));
  assign at_timeout = ((cycles + 32'd1) == 32'(TIMEOUT));
  assign ram_wdata  = {in_byte, asm_q};
  assign state      = cur;

  always_comb begin
    nxt = cur;
    case (cur)
      ST_LEN0: if (accept) nxt = ST_LEN1;
      ST_LEN1: if (accept) nxt = len_bad ? ST_ERR : ST_LOAD;
      ST_LOAD: if (word_done && last_word) nxt = ST_RUN;
      ST_RUN: begin
        if (core_halted) begin
          nxt = ST_DONE;
        end else if (at_timeout) begin
          nxt = ST_ERR;
        end
      end
      ST_DONE: nxt = ST_DONE;
      ST_ERR:  nxt = ST_ERR;
      default: nxt = ST_LEN0;
    endcase
  end

  // core_reset follows next state so the core leaves reset on the same edge RUN is entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur        <= ST_LEN0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      cur        <= nxt;
      core_reset <= (nxt != ST_RUN);
      done       <= done  | (nxt == ST_DONE);
      error      <= error | (nxt == ST_ERR);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      len_lo   <= '0;
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
      cycles   <= '0;
    end else begin
      if ((cur == ST_LEN0) && accept) begin
        len_lo <= in_byte;
      end
      if ((cur == ST_LEN1) && accept && !len_bad) begin
        n_words  <= n_len[ADDR_SIZE:0];
        word_idx <= '0;
        byte_idx <= '0;
      end
      if ((cur == ST_LOAD) && accept) begin
        asm_q <= {in_byte, asm_q[WORD_W-9:8]};
        if (word_done) begin
          byte_idx <= '0;
          word_idx <= word_idx + 1'b1;
        end else begin
          byte_idx <= byte_idx + 2'd1;
        end
      end
      if ((cur == ST_RUN) && !core_halted) begin
        cycles <= at_timeout ? 32'(TIMEOUT) : cycles + 32'd1;
      end
    end
  end

  imem_ram #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_W    (WORD_W)
  ) u_ram (
    .clock (clock),
    .we    (word_done),
    .waddr (word_idx),
    .wdata (ram_wdata),
    .raddr (raddr[ADDR_SIZE-1:0]),
    .rdata (ram_rdata)
  );

  // Full-width compare: an address beyond the program, even one that aliases in RAM, fetches BREAK.
  assign instr = (raddr < 32'(n_words)) ? ram_rdata : BREAK_INSTR;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader and instruction memory that sits directly upstream of the Mips32 core. It accepts a byte stream over a valid/ready handshake and assembles it into 32-bit words in on-chip instruction RAM. While the program loads, it holds the core in reset, then serves combinational instruction fetches to the core. It watches the core's halted flag and reports completion, a run-cycle count, or a timeout error to the bench/top.

Parameters:
ADDR_SIZE, 8, log2 of instruction RAM depth in 32-bit words (256 words)
TIMEOUT, 100000, maximum RUN cycles before the error state is forced

Ports:
clock  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high
in_valid  in  1  byte-stream valid
in_ready  out  1  byte-stream ready
in_byte  in  8  stream data
raddr  in  32  word-index fetch address from core
instr  out  32  fetched instruction (combinational)
core_reset  out  1  registered reset to core
core_halted  in  1  core halted flag
done  out  1  sticky: core halted normally
error  out  1  sticky: bad length or timeout
cycles  out  32  RUN cycle count
state  out  3  current FSM state (debug)

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named clock and reset.
- Reset values: state=LEN0, in_ready=1, core_reset=1, done=0, error=0, cycles=0, n_words=0. RAM contents are not reset and are preserved across reset.
- A byte is accepted on a posedge when in_valid && in_ready. in_ready=1 only in LEN0, LEN1 and LOAD. in_valid is ignored in all other states.
- Stream format: 16-bit little-endian word count N, followed by 4*N bytes. Each word is little-endian: the first byte goes to [7:0].
- LEN0: on accept, latch the low byte and go to LEN1.
- LEN1: on accept, N={byte,lo}.
  - N==0 or N>2**ADDR_SIZE: go to ERR.
  - Otherwise: n_words=N, word_idx=0, byte_idx=0, go to LOAD.
- LOAD: each accepted byte shifts into the assembly register.
  - On byte_idx==3, write {b3,b2,b1,b0} to ram[word_idx] at that edge, then word_idx++ and byte_idx=0.
  - On the write with word_idx==N-1, go to RUN.
- core_reset is registered: it equals (next_state != RUN), so it is 0 exactly in RUN cycles. In the first RUN cycle the core's pc is already 0 and instr=ram[0].
- Fetch path: instr = (raddr < n_words) ? ram[raddr[ADDR_SIZE-1:0]] : 32'h0000000D (BREAK). Fetching past the program end therefore halts the core. Upper raddr bits are compared, not truncated.
- RUN, evaluated at each posedge:
  - core_halted=1: go to DONE; cycles does not increment.
  - Else if cycles+1 == TIMEOUT: cycles=TIMEOUT, go to ERR.
  - Else cycles++.
- DONE: done=1, core_reset=1, cycles frozen. Exits only on reset.
- ERR: error=1, core_reset=1, cycles frozen. Exits only on reset. done and error are never both 1.
- Reset mid-operation (any state) returns to LEN0 next cycle. A partial word is discarded, and n_words=0 so all fetches return BREAK.
- State encoding: LEN0=0, LEN1=1, LOAD=2, RUN=3, DONE=4, ERR=5.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum (3 bits)
  - BREAK_INSTR=32'h0000000D
  - LEN_BYTES=2, WORD_BYTES=4
- Sub-module imem_ram: single write port and one asynchronous read port, parameterised by ADDR_SIZE, width 32. The FSM, assembler and counters stay in the top module.

Test Plan:
- Load the 9-word sum program (bytes 09 00, then 26 18 63 00 ...). Expected:
  - in_ready falls the cycle after byte 38; core_reset=0 the following cycle.
  - instr@0=0x00631826, instr@8=0x0040000D, instr@9=0x0000000D.
- Same program with in_valid toggling pseudo-randomly (gaps of 0-3 cycles). Expected: identical RAM image; only handshaken bytes are counted.
- Length bytes 00 00 -> error=1 and state=5 the cycle after the 2nd byte; in_ready=0; core_reset stays 1. Repeat with 01 01 (N=257, ADDR_SIZE=8) -> same result.
- Load N=1, then assert core_halted on the 21st RUN cycle. Expected: done=1, cycles=20, core_reset=1 next cycle; later in_valid is ignored.
- TIMEOUT=16 with core_halted held at 0. Expected: error=1 after the 16th RUN cycle, cycles=16, done=0.
- Assert reset after 5 bytes of an N=2 load. Expected: state=0, in_ready=1, instr@0=0x0000000D; a fresh complete load then runs normally.
